// File: rtl/tx_byte_sender_pkg.sv
// Shared types for the simulator-harness transmit path.
package ece270_sim_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_STROBE, TX_GAP} tx_state_t;
endpackage

// File: rtl/tx_byte_sender_fifo.sv
// Synchronous show-ahead byte FIFO; dout always presents the head entry.
module byte_fifo
  import ece270_sim_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push_ok, pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/tx_byte_sender.sv
// Queues user bytes and strobes them onto the harness txdata/txclk pins,
// one byte per SETUP/STROBE/GAP sequence, gated by txready in IDLE.
module tx_byte_sender
  import ece270_sim_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                    hz100,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [BYTE_W-1:0]       wr_data,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    busy,
  input  logic                    txready,
  output logic [BYTE_W-1:0]       txdata,
  output logic                    txclk
);
  localparam int TMAX0 = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int TMAX  = (TMAX0 > GAP_CYCLES) ? TMAX0 : GAP_CYCLES;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Timer holds "cycles remaining minus one" so a phase ends when it reads zero.
  localparam logic [TW-1:0] T_SETUP  = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] T_STROBE = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP    = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t         state;
  logic [TW-1:0]     timer;
  logic [BYTE_W-1:0] head;
  logic              empty, pop;

  assign pop = (state == TX_IDLE) && !empty && txready;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (hz100),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge hz100) begin
    if (reset) begin
      state    <= TX_IDLE;
      timer    <= '0;
      txdata   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      case (state)
        TX_IDLE: if (pop) begin
          txdata <= head;
          timer  <= T_SETUP;
          state  <= TX_SETUP;
        end
        TX_SETUP: if (timer == '0) begin
          timer <= T_STROBE;
          state <= TX_STROBE;
        end else begin
          timer <= timer - TW'(1);
        end
        TX_STROBE: if (timer == '0) begin
          timer <= T_GAP;
          state <= (GAP_CYCLES == 0) ? TX_IDLE : TX_GAP;
        end else begin
          timer <= timer - TW'(1);
        end
        TX_GAP: if (timer == '0) state <= TX_IDLE;
                else timer <= timer - TW'(1);
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign txclk = (state == TX_STROBE);
  assign busy  = (state != TX_IDLE);
endmodule

// File: tb/tb_tx_byte_sender.sv
// Randomized bench for tx_byte_sender: per-cycle window model plus a strobe scoreboard.
module tb_tx_byte_sender;
  localparam int DEPTH = 8;
  localparam int S = 1, ST = 2, G = 1;
  localparam int P = S + ST + G;

  logic       hz100 = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       txready = 1'b1;
  logic       full, overflow, busy, txclk;
  logic [3:0] count;
  logic [7:0] txdata;

  tx_byte_sender #(.DEPTH(DEPTH), .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .GAP_CYCLES(G)) dut (
    .hz100(hz100), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .overflow(overflow), .busy(busy),
    .txready(txready), .txdata(txdata), .txclk(txclk)
  );

  always #5 hz100 = ~hz100;

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes, position in the transfer window (-1 = idle).
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_pos = -1;
  logic [7:0] m_txdata = 8'h00;
  logic       m_ovf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit         was_full, do_pop;
    int         exp_clk;
    @(posedge hz100);
    if (reset) begin
      m_q.delete(); exp_q.delete();
      m_pos = -1; m_txdata = 8'h00; m_ovf = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_pos < 0) && (m_q.size() != 0) && txready;
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == P) m_pos = -1;
      end
      if (do_pop) begin
        m_txdata = m_q.pop_front();
        m_pos = 0;
      end
      if (wr_en) begin
        if (was_full) m_ovf = 1'b1;
        else begin
          m_q.push_back(wr_data);
          exp_q.push_back(wr_data);
        end
      end
    end
    #1;
    exp_clk = (m_pos >= S && m_pos < S + ST) ? 1 : 0;
    chk("count",    int'(count),    m_q.size());
    chk("full",     int'(full),     (m_q.size() == DEPTH) ? 1 : 0);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("busy",     int'(busy),     (m_pos >= 0) ? 1 : 0);
    chk("txclk",    int'(txclk),    exp_clk);
    chk("txdata",   int'(txdata),   int'(m_txdata));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  // Scoreboard monitor: every rising strobe must carry the next accepted byte.
  logic prev_clk = 1'b0;
  logic [7:0] strobe_byte;
  always @(negedge hz100) begin
    if (txclk && !prev_clk) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe_unexpected: txdata=%0h with nothing expected", txdata);
      end else begin
        strobe_byte = exp_q.pop_front();
        chk("strobe_byte", int'(txdata), int'(strobe_byte));
      end
    end
    prev_clk = txclk;
  end

  initial begin
    run(2);
    reset = 1'b0;
    txready = 1'b1;
    run(10);                                  // idle after reset

    wr(8'hA5); run(10);                       // single byte
    wr(8'h11); wr(8'h22); wr(8'h33); run(20); // back-to-back

    txready = 1'b0;                           // fill, overflow, drain
    for (int i = 0; i < 9; i++) wr(8'(8'hC0 + i));
    run(2);
    txready = 1'b1;
    run(50);

    wr(8'h5A); wr(8'h6B);                     // txready drops mid-strobe
    for (int i = 0; i < 20 && !(m_pos >= S && m_pos < S + ST); i++) step();
    txready = 1'b0;
    run(10);
    txready = 1'b1;
    run(15);

    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04); // reset during strobe
    for (int i = 0; i < 20 && !(m_pos >= S && m_pos < S + ST); i++) step();
    reset = 1'b1; step();
    reset = 1'b0; run(20);

    for (int i = 0; i < 800; i++) begin       // randomized traffic
      wr_en   = ($urandom_range(0, 99) < 35);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 99) < 15) txready = ~txready;
      reset   = ($urandom_range(0, 299) == 0);
      step();
    end
    wr_en = 1'b0; reset = 1'b0; txready = 1'b1;
    for (int i = 0; i < 200 && (m_q.size() != 0 || m_pos >= 0); i++) step();
    run(3);
    chk("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
